alu_operand_issue: RTL

- Execute-stage front end, directly upstream of the 64-bit ALU.
- Accepts decoded instructions from ID with a valid/ready handshake and resolves rs1/rs2 operands through EX/MEM forwarding and immediate selection.
- Registers the ALU inputs `in_rs1`, `in_rs2`, `in_funct3` and `in_funct7`, plus the destination tag.
- Holds a 2-entry skid buffer so back-pressure from EX never drops an instruction.

---
 rtl/alu_issue_pkg.sv | 46 ++++
 rtl/alu_operand_issue_fwd_mux.sv | 39 +++
 rtl/alu_operand_issue.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/alu_issue_pkg.sv
// Shared types and helpers for the ALU operand-issue stage: ALU op codes,
// forwarding-select encoding and funct7 normalisation / legality rules.
package alu_issue_pkg;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SLL  = 4'b0001;
  localparam logic [3:0] ALU_SLT  = 4'b0010;
  localparam logic [3:0] ALU_SLTU = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_OR   = 4'b0110;
  localparam logic [3:0] ALU_AND  = 4'b0111;
  localparam logic [3:0] ALU_SUB  = 4'b1000;
  localparam logic [3:0] ALU_SRA  = 4'b1101;

  localparam logic [2:0] FUNCT3_SHIFT_R = 3'b101;

  typedef enum logic [1:0] {FWD_RF, FWD_MEM, FWD_EX} fwd_sel_e;

  // I-type ops carry imm[11:5] in funct7; only the right-shift form keeps bit 5.
  function automatic logic [6:0] norm_funct7(input logic use_imm,
                                             input logic [2:0] funct3,
                                             input logic [6:0] funct7);
    logic [6:0] f7;
    f7 = funct7;
    if (use_imm) begin
      if (funct3 == FUNCT3_SHIFT_R) f7 = {1'b0, funct7[5], 5'b0};
      else                          f7 = 7'd0;
    end
    return f7;
  endfunction

  function automatic logic op_is_legal(input logic [2:0] funct3,
                                       input logic [6:0] funct7);
    logic legal;
    legal = 1'b0;
    case ({funct7[5], funct3})
      ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR,
      ALU_SRL, ALU_OR, ALU_AND, ALU_SUB, ALU_SRA: legal = 1'b1;
      default: legal = 1'b0;
    endcase
    if ((funct7 & 7'b101_1111) != 7'd0) legal = 1'b0;
    return legal;
  endfunction

endpackage

// File: rtl/alu_operand_issue_fwd_mux.sv
// Per-source forwarding comparator and mux: EX beats MEM beats register file;
// register x0 is never forwarded.
module operand_fwd_mux
  import alu_issue_pkg::*;
#(
  parameter int DATA_WIDTH     = 64,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic [REG_ADDR_WIDTH-1:0] src_addr,
  input  logic [DATA_WIDTH-1:0]     rf_data,
  input  logic                      ex_fwd_valid,
  input  logic [REG_ADDR_WIDTH-1:0] ex_fwd_addr,
  input  logic [DATA_WIDTH-1:0]     ex_fwd_data,
  input  logic                      mem_fwd_valid,
  input  logic [REG_ADDR_WIDTH-1:0] mem_fwd_addr,
  input  logic [DATA_WIDTH-1:0]     mem_fwd_data,
  output logic [DATA_WIDTH-1:0]     operand
);

  fwd_sel_e sel;

  always_comb begin
    sel = FWD_RF;
    if (src_addr != '0) begin
      if (ex_fwd_valid && (ex_fwd_addr == src_addr))        sel = FWD_EX;
      else if (mem_fwd_valid && (mem_fwd_addr == src_addr)) sel = FWD_MEM;
    end
  end

  always_comb begin
    operand = rf_data;
    case (sel)
      FWD_EX:  operand = ex_fwd_data;
      FWD_MEM: operand = mem_fwd_data;
      default: operand = rf_data;
    endcase
  end

endmodule

// File: rtl/alu_operand_issue.sv
// Execute-stage operand issue: forwarding, immediate select, registered ALU inputs
// behind a 2-entry (output + skid) buffer. Optional macro: ISSUE_ILLEGAL_OP_CHECK_EN.
module alu_operand_issue
  import alu_issue_pkg::*;
#(
  parameter int DATA_WIDTH     = 64,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      out_in_ready,
  input  logic [REG_ADDR_WIDTH-1:0] in_rs1_addr,
  input  logic [REG_ADDR_WIDTH-1:0] in_rs2_addr,
  input  logic [DATA_WIDTH-1:0]     in_rs1_data,
  input  logic [DATA_WIDTH-1:0]     in_rs2_data,
  input  logic [DATA_WIDTH-1:0]     in_imm,
  input  logic                      in_use_imm,
  input  logic [2:0]                in_funct3,
  input  logic [6:0]                in_funct7,
  input  logic [REG_ADDR_WIDTH-1:0] in_rd_addr,
  input  logic                      in_ex_fwd_valid,
  input  logic [REG_ADDR_WIDTH-1:0] in_ex_fwd_addr,
  input  logic [DATA_WIDTH-1:0]     in_ex_fwd_data,
  input  logic                      in_mem_fwd_valid,
  input  logic [REG_ADDR_WIDTH-1:0] in_mem_fwd_addr,
  input  logic [DATA_WIDTH-1:0]     in_mem_fwd_data,
  input  logic                      in_flush,
  output logic                      out_valid,
  input  logic                      in_ready,
  output logic [DATA_WIDTH-1:0]     out_rs1,
  output logic [DATA_WIDTH-1:0]     out_rs2,
  output logic [2:0]                out_funct3,
  output logic [6:0]                out_funct7,
  output logic [REG_ADDR_WIDTH-1:0] out_rd_addr
`ifdef ISSUE_ILLEGAL_OP_CHECK_EN
  ,
  output logic                      out_illegal_op
`endif
);

  logic [DATA_WIDTH-1:0]     fwd_rs1;
  logic [DATA_WIDTH-1:0]     fwd_rs2;
  logic [DATA_WIDTH-1:0]     new_rs2;
  logic [6:0]                new_funct7;
  logic                      op_legal;
  logic                      accept;
  logic                      push;
  logic                      drain;

  logic                      skid_valid;
  logic [DATA_WIDTH-1:0]     skid_rs1;
  logic [DATA_WIDTH-1:0]     skid_rs2;
  logic [2:0]                skid_funct3;
  logic [6:0]                skid_funct7;
  logic [REG_ADDR_WIDTH-1:0] skid_rd_addr;

  operand_fwd_mux #(.DATA_WIDTH(DATA_WIDTH), .REG_ADDR_WIDTH(REG_ADDR_WIDTH)) u_fwd_rs1 (
    .src_addr      (in_rs1_addr),
    .rf_data       (in_rs1_data),
    .ex_fwd_valid  (in_ex_fwd_valid),
    .ex_fwd_addr   (in_ex_fwd_addr),
    .ex_fwd_data   (in_ex_fwd_data),
    .mem_fwd_valid (in_mem_fwd_valid),
    .mem_fwd_addr  (in_mem_fwd_addr),
    .mem_fwd_data  (in_mem_fwd_data),
    .operand       (fwd_rs1)
  );

  operand_fwd_mux #(.DATA_WIDTH(DATA_WIDTH), .REG_ADDR_WIDTH(REG_ADDR_WIDTH)) u_fwd_rs2 (
    .src_addr      (in_rs2_addr),
    .rf_data       (in_rs2_data),
    .ex_fwd_valid  (in_ex_fwd_valid),
    .ex_fwd_addr   (in_ex_fwd_addr),
    .ex_fwd_data   (in_ex_fwd_data),
    .mem_fwd_valid (in_mem_fwd_valid),
    .mem_fwd_addr  (in_mem_fwd_addr),
    .mem_fwd_data  (in_mem_fwd_data),
    .operand       (fwd_rs2)
  );

  assign new_rs2      = in_use_imm ? in_imm : fwd_rs2;
  assign new_funct7   = norm_funct7(in_use_imm, in_funct3, in_funct7);
  // Ready is a pure function of the skid flop, so it never depends on in_ready.
  assign out_in_ready = ~skid_valid;
  assign accept       = in_valid & out_in_ready & ~in_flush;
  assign drain        = out_valid & in_ready;
  assign push         = accept & op_legal;

`ifdef ISSUE_ILLEGAL_OP_CHECK_EN
  assign op_legal = op_is_legal(in_funct3, new_funct7);

  always_ff @(posedge clk) begin
    if (reset) out_illegal_op <= 1'b0;
    else       out_illegal_op <= accept & ~op_legal;
  end
`else
  assign op_legal = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid    <= 1'b0;
      out_rs1      <= '0;
      out_rs2      <= '0;
      out_funct3   <= '0;
      out_funct7   <= '0;
      out_rd_addr  <= '0;
      skid_valid   <= 1'b0;
      skid_rs1     <= '0;
      skid_rs2     <= '0;
      skid_funct3  <= '0;
      skid_funct7  <= '0;
      skid_rd_addr <= '0;
    end else if (in_flush) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
    end else if (!out_valid || drain) begin
      // Output slot frees up: the older skid entry always goes first.
      if (skid_valid) begin
        out_rs1     <= skid_rs1;
        out_rs2     <= skid_rs2;
        out_funct3  <= skid_funct3;
        out_funct7  <= skid_funct7;
        out_rd_addr <= skid_rd_addr;
        skid_valid  <= 1'b0;
      end else if (push) begin
        out_valid   <= 1'b1;
        out_rs1     <= fwd_rs1;
        out_rs2     <= new_rs2;
        out_funct3  <= in_funct3;
        out_funct7  <= new_funct7;
        out_rd_addr <= in_rd_addr;
      end else begin
        out_valid <= 1'b0;
      end
    end else if (push) begin
      skid_valid   <= 1'b1;
      skid_rs1     <= fwd_rs1;
      skid_rs2     <= new_rs2;
      skid_funct3  <= in_funct3;
      skid_funct7  <= new_funct7;
      skid_rd_addr <= in_rd_addr;
    end
  end

endmodule
